// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one bram port between req 0 (CPU) and req 1 (DMA).
// Accepts one command per clock and returns read data to the issuer two cycles after the handshake.
module bram_port_arbiter #(
  parameter int unsigned P_DATA_WIDTH    = 16,
  parameter int unsigned P_ADDRESS_WIDTH = 10
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,

  input  logic                       I_REQ0_VALID,
  input  logic                       I_REQ0_WRITE_ENABLE,
  input  logic [P_ADDRESS_WIDTH-1:0] I_REQ0_ADDRESS,
  input  logic [P_DATA_WIDTH-1:0]    I_REQ0_DATA,
  output logic                       O_REQ0_READY,
  output logic                       O_REQ0_RVALID,
  output logic [P_DATA_WIDTH-1:0]    O_REQ0_RDATA,

  input  logic                       I_REQ1_VALID,
  input  logic                       I_REQ1_WRITE_ENABLE,
  input  logic [P_ADDRESS_WIDTH-1:0] I_REQ1_ADDRESS,
  input  logic [P_DATA_WIDTH-1:0]    I_REQ1_DATA,
  output logic                       O_REQ1_READY,
  output logic                       O_REQ1_RVALID,
  output logic [P_DATA_WIDTH-1:0]    O_REQ1_RDATA,

  output logic [P_ADDRESS_WIDTH-1:0] O_BRAM_ADDRESS,
  output logic [P_DATA_WIDTH-1:0]    O_BRAM_DATA,
  output logic                       O_BRAM_WRITE_ENABLE,
  input  logic [P_DATA_WIDTH-1:0]    I_BRAM_DATA
);

  logic                       grant0, grant1;
  logic                       pri_q, pri_d;
  logic [P_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [P_DATA_WIDTH-1:0]    data_q, data_d;
  logic                       we_q, we_d;
  logic                       s1_rd_q, s1_rd_d;
  logic                       s1_owner_q, s1_owner_d;
  logic                       s2_rd_q, s2_owner_q;

  // pri_q selects the winner only when both requesters are valid.
  always_comb begin
    grant0 = I_REQ0_VALID & (~I_REQ1_VALID | ~pri_q);
    grant1 = I_REQ1_VALID & (~I_REQ0_VALID | pri_q);
  end

  always_comb begin
    pri_d      = pri_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    s1_rd_d    = 1'b0;
    s1_owner_d = s1_owner_q;
    if (grant0) begin
      pri_d      = 1'b1;
      addr_d     = I_REQ0_ADDRESS;
      data_d     = I_REQ0_DATA;
      we_d       = I_REQ0_WRITE_ENABLE;
      s1_rd_d    = ~I_REQ0_WRITE_ENABLE;
      s1_owner_d = 1'b0;
    end else if (grant1) begin
      pri_d      = 1'b0;
      addr_d     = I_REQ1_ADDRESS;
      data_d     = I_REQ1_DATA;
      we_d       = I_REQ1_WRITE_ENABLE;
      s1_rd_d    = ~I_REQ1_WRITE_ENABLE;
      s1_owner_d = 1'b1;
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      pri_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      s1_rd_q    <= 1'b0;
      s1_owner_q <= 1'b0;
      s2_rd_q    <= 1'b0;
      s2_owner_q <= 1'b0;
    end else begin
      pri_q      <= pri_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      s1_rd_q    <= s1_rd_d;
      s1_owner_q <= s1_owner_d;
      s2_rd_q    <= s1_rd_q;
      s2_owner_q <= s1_owner_q;
    end
  end

  // Readies and read data are forced low while reset is asserted.
  always_comb begin
    O_REQ0_READY        = grant0 & I_NRESET;
    O_REQ1_READY        = grant1 & I_NRESET;
    O_REQ0_RVALID       = s2_rd_q & ~s2_owner_q;
    O_REQ1_RVALID       = s2_rd_q & s2_owner_q;
    O_REQ0_RDATA        = O_REQ0_RVALID ? I_BRAM_DATA : '0;
    O_REQ1_RDATA        = O_REQ1_RVALID ? I_BRAM_DATA : '0;
    O_BRAM_ADDRESS      = addr_q;
    O_BRAM_DATA         = data_q;
    O_BRAM_WRITE_ENABLE = we_q;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant rule, reference memory, queue of due responses).
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        r0_v = 1'b0, r0_we = 1'b0, r1_v = 1'b0, r1_we = 1'b0;
  logic [9:0]  r0_a = '0, r1_a = '0;
  logic [15:0] r0_d = '0, r1_d = '0;
  logic        r0_rdy, r0_rv, r1_rdy, r1_rv;
  logic [15:0] r0_rd, r1_rd;
  logic [9:0]  b_addr;
  logic [15:0] b_data;
  logic        b_we;
  logic [15:0] b_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  bram_port_arbiter #(
    .P_DATA_WIDTH   (16),
    .P_ADDRESS_WIDTH(10)
  ) dut (
    .I_CLK              (clk),
    .I_NRESET           (nrst),
    .I_REQ0_VALID       (r0_v),
    .I_REQ0_WRITE_ENABLE(r0_we),
    .I_REQ0_ADDRESS     (r0_a),
    .I_REQ0_DATA        (r0_d),
    .O_REQ0_READY       (r0_rdy),
    .O_REQ0_RVALID      (r0_rv),
    .O_REQ0_RDATA       (r0_rd),
    .I_REQ1_VALID       (r1_v),
    .I_REQ1_WRITE_ENABLE(r1_we),
    .I_REQ1_ADDRESS     (r1_a),
    .I_REQ1_DATA        (r1_d),
    .O_REQ1_READY       (r1_rdy),
    .O_REQ1_RVALID      (r1_rv),
    .O_REQ1_RDATA       (r1_rd),
    .O_BRAM_ADDRESS     (b_addr),
    .O_BRAM_DATA        (b_data),
    .O_BRAM_WRITE_ENABLE(b_we),
    .I_BRAM_DATA        (b_rdata)
  );

  always #5 clk = ~clk;

  // Environment bram: synchronous read, one clock latency.
  logic [15:0] env_mem [1024];
  always @(posedge clk) begin
    b_rdata <= env_mem[b_addr];
    if (b_we) env_mem[b_addr] = b_data;
  end

  // Reference model state.
  typedef struct {
    int          due;
    bit          owner;
    logic [15:0] data;
  } resp_t;

  logic [15:0] ref_mem [1024];
  resp_t       rq[$];
  int          cyc = 0;
  int          m_g;
  bit          m_pri = 1'b0;
  logic        m_we = 1'b0;
  logic [9:0]  m_addr = '0;
  logic [15:0] m_data = '0;

  function automatic int pick(logic v0, logic v1, bit pri);
    if (v0 && v1) return pri ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_pri  = 1'b0;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      rq.delete();
    end else begin
      resp_t       r;
      logic        we;
      logic [9:0]  a;
      logic [15:0] d;
      cyc++;
      while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
      m_g  = pick(r0_v, r1_v, m_pri);
      m_we = 1'b0;
      if (m_g >= 0) begin
        m_pri = (r0_v && r1_v) ? !m_pri : (m_g == 0);
        we    = (m_g == 1) ? r1_we : r0_we;
        a     = (m_g == 1) ? r1_a : r0_a;
        d     = (m_g == 1) ? r1_d : r0_d;
        m_we   = we;
        m_addr = a;
        m_data = d;
        if (we) begin
          ref_mem[a] = d;
        end else begin
          r.due   = cyc + 1;
          r.owner = (m_g == 1);
          r.data  = ref_mem[a];
          rq.push_back(r);
        end
      end
    end
  end

  task automatic idle_inputs;
    r0_v = 1'b0; r0_we = 1'b0; r1_v = 1'b0; r1_we = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    idle_inputs();
    @(negedge clk) nrst = 1'b0;
    @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    next_cycle();
  endtask

  task automatic drain;
    idle_inputs();
    repeat (3) next_cycle();
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    r0_v = 1'b1; r1_v = 1'b1;
    #1;
    n_cmp++;
    if ({r0_rdy, r0_rv, r0_rd, r1_rdy, r1_rv, r1_rd, b_addr, b_data, b_we} !== 63'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got rdy0=%b rdy1=%b rv0=%b rv1=%b addr=%h we=%b want all 0",
               r0_rdy, r1_rdy, r0_rv, r1_rv, b_addr, b_we);
    end
    repeat (2) @(posedge clk);
    idle_inputs();
    @(negedge clk) nrst = 1'b1;
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({r0_rv, r1_rv, b_addr, b_data, b_we} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_release got rv0=%b rv1=%b addr=%h data=%h we=%b want all 0",
               r0_rv, r1_rv, b_addr, b_data, b_we);
    end
    next_cycle();
  endtask

  task automatic test_single_read;
    r0_v = 1'b1; r0_we = 1'b0; r0_a = 10'd5; r0_d = 16'($urandom);
    @(negedge clk);
    n_cmp++;
    if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_ready got rdy0=%b rdy1=%b want 1/0", r0_rdy, r1_rdy);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (b_addr !== 10'd5 || b_we !== 1'b0 || r0_rv !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_bram_cmd got addr=%h we=%b rv0=%b want 005/0/0", b_addr, b_we, r0_rv);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (r0_rv !== 1'b1 || r0_rd !== 16'h0006 || r1_rv !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_rdata got rv0=%b rd0=%h rv1=%b want 1/0006/0", r0_rv, r0_rd, r1_rv);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (r0_rv !== 1'b0 || r1_rv !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_rvalid_once got rv0=%b rv1=%b want 0/0", r0_rv, r1_rv);
    end
    next_cycle();
  endtask

  task automatic test_alternate;
    int v1s[5] = '{1, 1, 1, 1, 0};
    int a0s[5] = '{0, 2, 2, 4, 4};
    int a1s[5] = '{1, 1, 3, 3, 3};
    int gs[5]  = '{0, 1, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        r0_v = 1'b1; r0_we = 1'b0; r0_a = 10'(a0s[i]);
        r1_v = (v1s[i] == 1); r1_we = 1'b0; r1_a = 10'(a1s[i]);
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (i < 5) begin
        n_cmp++;
        if (r0_rdy !== (gs[i] == 0) || r1_rdy !== (gs[i] == 1)) begin
          n_bad++;
          $display("FAIL t2_grant[%0d] got rdy0=%b rdy1=%b want grant %0d", i, r0_rdy, r1_rdy, gs[i]);
        end
      end
      if (i >= 2) begin
        int          j;
        logic [15:0] got;
        j   = i - 2;
        got = (gs[j] == 1) ? r1_rd : r0_rd;
        n_cmp++;
        if (r0_rv !== (gs[j] == 0) || r1_rv !== (gs[j] == 1) || got !== ref_mem[j]) begin
          n_bad++;
          $display("FAIL t2_resp[%0d] got rv0=%b rv1=%b data=%h want owner %0d data=%h",
                   j, r0_rv, r1_rv, got, gs[j], ref_mem[j]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_write_then_read;
    r1_v = 1'b1; r1_we = 1'b1; r1_a = 10'd3; r1_d = 16'hBEEF;
    @(negedge clk);
    n_cmp++;
    if (r1_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL t3_ready1 got %b want 1", r1_rdy);
    end
    next_cycle();
    r1_v = 1'b0; r1_we = 1'b0;
    r0_v = 1'b1; r0_we = 1'b0; r0_a = 10'd3;
    @(negedge clk);
    n_cmp++;
    if (b_we !== 1'b1 || b_addr !== 10'd3 || b_data !== 16'hBEEF || r0_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL t3_write_cmd got we=%b addr=%h data=%h rdy0=%b want 1/003/beef/1",
               b_we, b_addr, b_data, r0_rdy);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (r0_rv !== 1'b0 || b_we !== 1'b0) begin
      n_bad++;
      $display("FAIL t3_early got rv0=%b we=%b want 0/0", r0_rv, b_we);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (r0_rv !== 1'b1 || r0_rd !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL t3_readback got rv0=%b rd0=%h want 1/beef", r0_rv, r0_rd);
    end
    next_cycle();
  endtask

  task automatic test_reset_inflight;
    r0_v = 1'b1; r0_we = 1'b0; r0_a = 10'd7;
    @(negedge clk);
    n_cmp++;
    if (r0_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL t4_ready0 got %b want 1", r0_rdy);
    end
    next_cycle();
    r1_v = 1'b1;
    nrst = 1'b0;
    #1;
    n_cmp++;
    if ({r0_rdy, r0_rv, r0_rd, r1_rdy, r1_rv, r1_rd, b_addr, b_data, b_we} !== 63'd0) begin
      n_bad++;
      $display("FAIL t4_reset_now got rdy0=%b rdy1=%b rv0=%b addr=%h data=%h we=%b want all 0",
               r0_rdy, r1_rdy, r0_rv, b_addr, b_data, b_we);
    end
    @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    idle_inputs();
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (r0_rv !== 1'b0 || r1_rv !== 1'b0) begin
        n_bad++;
        $display("FAIL t4_no_rvalid[%0d] got rv0=%b rv1=%b want 0/0", i, r0_rv, r1_rv);
      end
      next_cycle();
    end
    r0_v = 1'b1; r0_a = 10'd8; r1_v = 1'b1; r1_a = 10'd9;
    @(negedge clk);
    n_cmp++;
    if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL t4_first_contest got rdy0=%b rdy1=%b want 1/0", r0_rdy, r1_rdy);
    end
    next_cycle();
    r0_v = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (r1_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL t4_ready1 got %b want 1", r1_rdy);
    end
    next_cycle();
    drain();
  endtask

  task automatic test_pri_after_solo;
    for (int i = 0; i < 3; i++) begin
      r0_v = 1'b1; r0_we = 1'b0; r0_a = 10'(10 + i); r1_v = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (r0_rdy !== 1'b1) begin
        n_bad++;
        $display("FAIL t5_solo[%0d] got rdy0=%b want 1", i, r0_rdy);
      end
      next_cycle();
    end
    r0_a = 10'd13; r1_v = 1'b1; r1_we = 1'b0; r1_a = 10'd20;
    @(negedge clk);
    n_cmp++;
    if (r1_rdy !== 1'b1 || r0_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_pri1 got rdy0=%b rdy1=%b want 0/1", r0_rdy, r1_rdy);
    end
    next_cycle();
    r1_v = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (r0_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL t5_then0 got rdy0=%b want 1", r0_rdy);
    end
    next_cycle();
    drain();
  endtask

  task automatic test_top_address;
    r0_v = 1'b1; r0_we = 1'b1; r0_a = 10'h3FF; r0_d = 16'h1234;
    next_cycle();
    r0_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b_addr !== 10'h3FF || b_we !== 1'b1 || b_data !== 16'h1234 || r0_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL t6_write_top got addr=%h we=%b data=%h rdy0=%b want 3ff/1/1234/1",
               b_addr, b_we, b_data, r0_rdy);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (r0_rv !== 1'b1 || r0_rd !== 16'h1234) begin
      n_bad++;
      $display("FAIL t6_read_top got rv0=%b rd0=%h want 1/1234", r0_rv, r0_rd);
    end
    next_cycle();
  endtask

  task automatic test_random;
    bit acc0 = 1'b1;
    bit acc1 = 1'b1;
    for (int c = 0; c < 400; c++) begin
      int  g;
      bit  ev0, ev1;
      if (acc0 || !r0_v) begin
        r0_v  = ($urandom_range(0, 9) < 6);
        r0_we = ($urandom_range(0, 2) == 0);
        r0_a  = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
        r0_d  = 16'($urandom);
      end
      if (acc1 || !r1_v) begin
        r1_v  = ($urandom_range(0, 9) < 6);
        r1_we = ($urandom_range(0, 2) == 0);
        r1_a  = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
        r1_d  = 16'($urandom);
      end
      @(negedge clk);
      g   = pick(r0_v, r1_v, m_pri);
      ev0 = (rq.size() > 0) && (rq[0].due == cyc) && !rq[0].owner;
      ev1 = (rq.size() > 0) && (rq[0].due == cyc) && rq[0].owner;
      n_cmp++;
      if (r0_rdy !== (g == 0) || r1_rdy !== (g == 1)) begin
        n_bad++;
        $display("FAIL rnd_grant c=%0d got rdy0=%b rdy1=%b want grant %0d", c, r0_rdy, r1_rdy, g);
      end
      n_cmp++;
      if (r0_rv !== ev0 || r1_rv !== ev1) begin
        n_bad++;
        $display("FAIL rnd_rvalid c=%0d got rv0=%b rv1=%b want %b/%b", c, r0_rv, r1_rv, ev0, ev1);
      end
      if (ev0 || ev1) begin
        n_cmp++;
        if ((ev0 ? r0_rd : r1_rd) !== rq[0].data) begin
          n_bad++;
          $display("FAIL rnd_rdata c=%0d got %h want %h", c, ev0 ? r0_rd : r1_rd, rq[0].data);
        end
      end
      n_cmp++;
      if (b_we !== m_we || b_addr !== m_addr || b_data !== m_data) begin
        n_bad++;
        $display("FAIL rnd_bram c=%0d got we=%b addr=%h data=%h want %b/%h/%h",
                 c, b_we, b_addr, b_data, m_we, m_addr, m_data);
      end
      acc0 = (g == 0);
      acc1 = (g == 1);
      next_cycle();
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[5] = 16'h0006;
    ref_mem[5] = 16'h0006;
    test_reset();
    test_single_read();
    apply_reset();
    test_alternate();
    test_write_then_read();
    test_reset_inflight();
    test_pri_after_solo();
    test_top_address();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached after %0d comparisons", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
